irq_controller: RTL and testbench

Interrupt controller that drives the control path's `irq` request and services its `reset_irq` acknowledge. It synchronises external interrupt sources, latches rising edges as pending bits, applies a mask and a global enable, and presents the highest-priority vector on `irq_addr`, which the control path loads into PC in its IRQ jump sequence. Software programs mask, enable and vectors over a small memory-mapped register port.

---
 rtl/irq_controller_pkg.sv | 24 ++
 rtl/irq_sync_edge.sv | 27 ++
 rtl/irq_controller.sv | 163 ++++++++++++++++
 tb/tb_irq_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_controller_pkg.sv
// rtl/irq_controller_pkg.sv - shared types and register map for the interrupt controller
package irq_controller_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    REQUEST = 1'b1
  } irq_state_t;

  localparam int VECTOR_WIDTH = 16;
  localparam int ID_WIDTH     = 3;
  localparam int MAX_SOURCES  = 8;

  localparam logic [3:0] ADDR_MASK        = 4'd0;
  localparam logic [3:0] ADDR_PENDING     = 4'd1;
  localparam logic [3:0] ADDR_IE          = 4'd2;
  localparam logic [3:0] ADDR_ACTIVE      = 4'd3;
  localparam logic [3:0] ADDR_VECTOR_BASE = 4'd8;

  // Vector slots live at 8..15; only slots below the source count exist.
  function automatic logic vector_addr_hit(input logic [3:0] addr, input int num_sources);
    return addr[3] && (int'(addr[2:0]) < num_sources);
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - two-flop synchroniser and rising-edge detector for one source
module irq_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic src,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= src;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - pending/mask/enable register file, fixed-priority encoder and request FSM
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int NUM_SOURCES = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_SOURCES-1:0]  irq_src,
  output logic                    irq,
  output logic [VECTOR_WIDTH-1:0] irq_addr,
  input  logic                    reset_irq,
  input  logic                    mmio_write,
  input  logic [3:0]              mmio_addr,
  input  logic [15:0]             mmio_wdata,
  output logic [15:0]             mmio_rdata
);

  logic [NUM_SOURCES-1:0]  rise;
  logic [NUM_SOURCES-1:0]  mask_q;
  logic [NUM_SOURCES-1:0]  pending_q;
  logic [NUM_SOURCES-1:0]  pending_d;
  logic [NUM_SOURCES-1:0]  w1c;
  logic [NUM_SOURCES-1:0]  ack_clr;
  logic [NUM_SOURCES-1:0]  eligible;
  logic                    ie_q;
  logic [VECTOR_WIDTH-1:0] vector_q [MAX_SOURCES];

  irq_state_t              state_q;
  irq_state_t              state_d;
  logic [ID_WIDTH-1:0]     id_q;
  logic [ID_WIDTH-1:0]     id_d;
  logic                    irq_d;
  logic [VECTOR_WIDTH-1:0] irq_addr_d;
  logic [ID_WIDTH-1:0]     win_id;
  logic                    win_any;
  logic                    ack;

  logic                    wr_mask;
  logic                    wr_pending;
  logic                    wr_ie;
  logic                    wr_vector;
  logic                    rd_vector;

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_src
    irq_sync_edge u_sync_edge (
      .clock (clock),
      .reset (reset),
      .src   (irq_src[g]),
      .rise  (rise[g])
    );
  end

  assign wr_mask    = mmio_write && (mmio_addr == ADDR_MASK);
  assign wr_pending = mmio_write && (mmio_addr == ADDR_PENDING);
  assign wr_ie      = mmio_write && (mmio_addr == ADDR_IE);
  assign rd_vector  = vector_addr_hit(mmio_addr, NUM_SOURCES);
  assign wr_vector  = mmio_write && rd_vector;

  assign ack     = (state_q == REQUEST) && reset_irq;
  assign w1c     = wr_pending ? mmio_wdata[NUM_SOURCES-1:0] : '0;
  assign ack_clr = ack ? (NUM_SOURCES'(1) << id_q) : '0;

  // A new edge in the same cycle as its clear must not be lost.
  assign pending_d = (pending_q & ~(w1c | ack_clr)) | rise;

  assign eligible = pending_q & mask_q & {NUM_SOURCES{ie_q}};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mask_q    <= '0;
      pending_q <= '0;
      ie_q      <= 1'b0;
      for (int i = 0; i < MAX_SOURCES; i++) begin
        vector_q[i] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      if (wr_mask) begin
        mask_q <= mmio_wdata[NUM_SOURCES-1:0];
      end
      // Acknowledge drops IE so the handler is entered once; it outranks a software write.
      if (ack) begin
        ie_q <= 1'b0;
      end else if (wr_ie) begin
        ie_q <= mmio_wdata[0];
      end
      if (wr_vector) begin
        vector_q[mmio_addr[2:0]] <= mmio_wdata;
      end
    end
  end

  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_any = 1'b1;
        win_id  = ID_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      id_q     <= '0;
      irq      <= 1'b0;
      irq_addr <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      irq      <= irq_d;
      irq_addr <= irq_addr_d;
    end
  end

  // Once in REQUEST the request is frozen; only the acknowledge releases it.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    irq_d      = irq;
    irq_addr_d = irq_addr;
    case (state_q)
      IDLE: begin
        irq_d = 1'b0;
        if (win_any) begin
          state_d    = REQUEST;
          id_d       = win_id;
          irq_d      = 1'b1;
          irq_addr_d = vector_q[win_id];
        end
      end
      REQUEST: begin
        if (reset_irq) begin
          state_d = IDLE;
          irq_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    mmio_rdata = '0;
    case (mmio_addr)
      ADDR_MASK:    mmio_rdata = 16'(mask_q);
      ADDR_PENDING: mmio_rdata = 16'(pending_q);
      ADDR_IE:      mmio_rdata = {15'b0, ie_q};
      ADDR_ACTIVE:  mmio_rdata = {(state_q == REQUEST), 12'b0, id_q};
      default: begin
        if (rd_vector) begin
          mmio_rdata = vector_q[mmio_addr[2:0]];
        end
      end
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed and randomized self-checking bench for irq_controller
module tb_irq_controller;

  logic        clock;
  logic        reset;
  logic [7:0]  irq_src;
  logic        irq;
  logic [15:0] irq_addr;
  logic        reset_irq;
  logic        mmio_write;
  logic [3:0]  mmio_addr;
  logic [15:0] mmio_wdata;
  logic [15:0] mmio_rdata;

  int tests;
  int fails;

  irq_controller #(.NUM_SOURCES(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .irq_src    (irq_src),
    .irq        (irq),
    .irq_addr   (irq_addr),
    .reset_irq  (reset_irq),
    .mmio_write (mmio_write),
    .mmio_addr  (mmio_addr),
    .mmio_wdata (mmio_wdata),
    .mmio_rdata (mmio_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [15:0] data);
    mmio_write = 1'b1;
    mmio_addr  = addr;
    mmio_wdata = data;
    tick();
    mmio_write = 1'b0;
    mmio_addr  = 4'd0;
    mmio_wdata = 16'd0;
  endtask

  task automatic rd(input logic [3:0] addr, output logic [15:0] data);
    mmio_addr = addr;
    #1;
    data = mmio_rdata;
  endtask

  task automatic ack_pulse();
    reset_irq = 1'b1;
    tick();
    reset_irq = 1'b0;
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  logic [15:0] rdata;
  logic [15:0] vec [8];
  logic [7:0]  m_mask;
  logic [7:0]  m_src;
  logic [7:0]  m_pend;
  logic [7:0]  m_elig;
  int          id;

  initial begin
    tests      = 0;
    fails      = 0;
    reset      = 1'b0;
    irq_src    = 8'h00;
    reset_irq  = 1'b0;
    mmio_write = 1'b0;
    mmio_addr  = 4'd0;
    mmio_wdata = 16'd0;

    repeat (3) @(posedge clock);
    #1;
    chk("reset_irq_out", irq, 1'b0);
    chk("reset_irq_addr", irq_addr, 16'h0000);
    rd(4'd0, rdata); chk("reset_mask", rdata, 16'h0000);
    rd(4'd1, rdata); chk("reset_pending", rdata, 16'h0000);
    rd(4'd3, rdata); chk("reset_active", rdata, 16'h0000);
    reset = 1'b1;
    tick();

    // Single source with exact latency.
    wr(4'd11, 16'h0400);
    wr(4'd0, 16'h0008);
    wr(4'd2, 16'h0001);
    irq_src[3] = 1'b1;
    repeat (3) tick();
    chk("single_not_yet", irq, 1'b0);
    tick();
    chk("single_irq", irq, 1'b1);
    chk("single_addr", irq_addr, 16'h0400);
    rd(4'd3, rdata); chk("single_active", rdata, 16'h8003);
    ack_pulse();
    chk("single_ack_irq", irq, 1'b0);
    rd(4'd1, rdata); chk("single_ack_pending", rdata, 16'h0000);
    rd(4'd2, rdata); chk("single_ack_ie", rdata, 16'h0000);
    irq_src = 8'h00;
    repeat (3) tick();

    // Priority and back-to-back after re-enable.
    wr(4'd10, 16'h0200);
    wr(4'd13, 16'h0500);
    wr(4'd0, 16'h00FF);
    wr(4'd2, 16'h0001);
    irq_src = 8'h24;
    repeat (4) tick();
    chk("prio_irq", irq, 1'b1);
    chk("prio_addr", irq_addr, 16'h0200);
    ack_pulse();
    chk("prio_ack_irq", irq, 1'b0);
    rd(4'd1, rdata); chk("prio_pending", rdata, 16'h0020);
    tick();
    chk("prio_ie_gates", irq, 1'b0);
    wr(4'd2, 16'h0001);
    chk("b2b_not_yet", irq, 1'b0);
    tick();
    chk("b2b_irq", irq, 1'b1);
    chk("b2b_addr", irq_addr, 16'h0500);
    ack_pulse();
    irq_src = 8'h00;
    repeat (3) tick();

    // Masked source, unmask, then W1C while idle.
    wr(4'd9, 16'h0100);
    wr(4'd0, 16'h0000);
    wr(4'd2, 16'h0001);
    irq_src[1] = 1'b1;
    repeat (4) tick();
    chk("masked_irq", irq, 1'b0);
    rd(4'd1, rdata); chk("masked_pending", rdata, 16'h0002);
    wr(4'd0, 16'h0002);
    chk("unmask_not_yet", irq, 1'b0);
    tick();
    chk("unmask_irq", irq, 1'b1);
    chk("unmask_addr", irq_addr, 16'h0100);
    ack_pulse();
    irq_src = 8'h00;
    repeat (2) tick();
    irq_src[1] = 1'b1;
    repeat (4) tick();
    chk("w1c_idle_irq", irq, 1'b0);
    rd(4'd1, rdata); chk("w1c_before", rdata, 16'h0002);
    wr(4'd1, 16'h0002);
    rd(4'd1, rdata); chk("w1c_after", rdata, 16'h0000);
    irq_src = 8'h00;
    repeat (3) tick();

    // Frozen request.
    wr(4'd14, 16'h0660);
    wr(4'd0, 16'h0040);
    wr(4'd2, 16'h0001);
    irq_src[6] = 1'b1;
    repeat (4) tick();
    chk("frozen_irq", irq, 1'b1);
    chk("frozen_addr", irq_addr, 16'h0660);
    wr(4'd0, 16'h0000);
    wr(4'd14, 16'hFFFF);
    wr(4'd2, 16'h0000);
    wr(4'd1, 16'h0040);
    repeat (2) tick();
    chk("frozen_irq_hold", irq, 1'b1);
    chk("frozen_addr_hold", irq_addr, 16'h0660);
    rd(4'd3, rdata); chk("frozen_active", rdata, 16'h8006);
    rd(4'd14, rdata); chk("frozen_vec_rd", rdata, 16'hFFFF);
    ack_pulse();
    chk("frozen_release", irq, 1'b0);
    irq_src = 8'h00;
    repeat (3) tick();

    // New edge on the acknowledge cycle keeps the pending bit.
    wr(4'd12, 16'h0440);
    wr(4'd0, 16'h0010);
    wr(4'd2, 16'h0001);
    irq_src[4] = 1'b1;
    repeat (4) tick();
    chk("setwins_irq", irq, 1'b1);
    chk("setwins_addr", irq_addr, 16'h0440);
    irq_src[4] = 1'b0;
    repeat (2) tick();
    irq_src[4] = 1'b1;
    repeat (2) tick();
    ack_pulse();
    chk("setwins_ack_irq", irq, 1'b0);
    rd(4'd1, rdata); chk("setwins_pending", rdata, 16'h0010);
    rd(4'd2, rdata); chk("setwins_ie", rdata, 16'h0000);
    wr(4'd2, 16'h0001);
    tick();
    chk("setwins_rearm", irq, 1'b1);

    // Asynchronous reset in the middle of a request.
    irq_src = 8'h00;
    reset = 1'b0;
    #1;
    chk("midreset_irq", irq, 1'b0);
    rd(4'd1, rdata); chk("midreset_pending", rdata, 16'h0000);
    rd(4'd0, rdata); chk("midreset_mask", rdata, 16'h0000);
    rd(4'd2, rdata); chk("midreset_ie", rdata, 16'h0000);
    tick();
    reset = 1'b1;
    rd(4'd11, rdata); chk("midreset_vec3", rdata, 16'h0000);
    rd(4'd7, rdata); chk("unmapped_rd", rdata, 16'h0000);
    repeat (3) tick();
    chk("midreset_idle", irq, 1'b0);

    // Randomized rounds against a priority/pending model.
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 8; i++) begin
        vec[i] = 16'($urandom);
        wr(4'(8 + i), vec[i]);
      end
      m_mask = 8'($urandom);
      m_src  = 8'($urandom_range(0, 255));
      wr(4'd0, {8'h00, m_mask});
      wr(4'd2, 16'h0001);
      irq_src = m_src;
      repeat (4) tick();
      m_pend = m_src;
      m_elig = m_src & m_mask;
      if (m_elig == 8'h00) begin
        chk("rnd_quiet_irq", irq, 1'b0);
        rd(4'd1, rdata); chk("rnd_quiet_pending", rdata, {8'h00, m_pend});
      end
      while (m_elig != 8'h00) begin
        id = lowest(m_elig);
        chk("rnd_irq", irq, 1'b1);
        chk("rnd_addr", irq_addr, vec[id]);
        rd(4'd3, rdata); chk("rnd_active", rdata, 16'h8000 | 16'(id));
        ack_pulse();
        chk("rnd_ack_irq", irq, 1'b0);
        m_pend[id] = 1'b0;
        m_elig[id] = 1'b0;
        rd(4'd1, rdata); chk("rnd_pending", rdata, {8'h00, m_pend});
        if (m_elig != 8'h00) begin
          wr(4'd2, 16'h0001);
          tick();
        end
      end
      irq_src = 8'h00;
      wr(4'd1, 16'h00FF);
      wr(4'd2, 16'h0000);
      repeat (3) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
